// File: rtl/mslope_pkg.sv
// -----------------------------------------------------------------------------
// mslope_pkg
//   Shared types for the multi-slope conversion sequencer.
//   - state_t  : sequencer state encoding (3 bits)
//   - sw_t     : integrator switch bundle, exactly one bit high outside IDLE/DONE
//   - result_t : field layout of one conversion result at the default widths
//   - sw_decode / is_fine : helpers for the switch decode and fine-slope test
// -----------------------------------------------------------------------------
package mslope_pkg;

   localparam int RD_W_DEF = 12;
   localparam int FN_W_DEF = 8;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ZERO    = 3'd1,
      ST_RUNUP   = 3'd2,
      ST_RUNDOWN = 3'd3,
      ST_N64     = 3'd4,
      ST_P8      = 3'd5,
      ST_N1      = 3'd6,
      ST_DONE    = 3'd7
   } state_t;

   typedef struct packed {
      logic szero;
      logic sinput;
      logic sp512;
      logic sn64;
      logic sp8;
      logic sn1;
   } sw_t;

   typedef struct packed {
      logic [31:0]         a;
      logic [31:0]         b;
      logic [RD_W_DEF-1:0] rd;
      logic [FN_W_DEF-1:0] n64;
      logic [FN_W_DEF-1:0] p8;
      logic [FN_W_DEF-1:0] n1;
      logic                err;
   } result_t;

   // One switch per active phase; IDLE and DONE open every switch.
   function automatic sw_t sw_decode(input state_t s);
      sw_t sw;
      sw = '0;
      case (s)
         ST_ZERO:    sw.szero  = 1'b1;
         ST_RUNUP:   sw.sinput = 1'b1;
         ST_RUNDOWN: sw.sp512  = 1'b1;
         ST_N64:     sw.sn64   = 1'b1;
         ST_P8:      sw.sp8    = 1'b1;
         ST_N1:      sw.sn1    = 1'b1;
         default:    sw        = '0;
      endcase
      return sw;
   endfunction

   function automatic logic is_fine(input state_t s);
      return (s == ST_N64) || (s == ST_P8) || (s == ST_N1);
   endfunction

endpackage

// File: rtl/conv_sequencer_if.sv
// -----------------------------------------------------------------------------
// conv_sequencer_if
//   Result hand-off from the conversion sequencer to the host reader.
//   Handshake: a result transfers on every clock where res_valid and res_ready
//   are both high. Once res_valid rises, all res_* data fields stay constant
//   until that transfer; res_valid never drops without a transfer (except on
//   reset). res_ready may be driven freely and does not depend on res_valid.
//   Signals: res_valid, res_ready, res_a, res_b (32), res_rd (RD_W),
//            res_n64/res_p8/res_n1 (FN_W), res_err.
//   Modports: master = sequencer side, slave = host side.
// -----------------------------------------------------------------------------
interface conv_sequencer_if #(
   parameter int RD_W = 12,
   parameter int FN_W = 8
);
   logic            res_valid;
   logic            res_ready;
   logic [31:0]     res_a;
   logic [31:0]     res_b;
   logic [RD_W-1:0] res_rd;
   logic [FN_W-1:0] res_n64;
   logic [FN_W-1:0] res_p8;
   logic [FN_W-1:0] res_n1;
   logic            res_err;

   modport master (
      output res_valid, res_a, res_b, res_rd, res_n64, res_p8, res_n1, res_err,
      input  res_ready
   );

   modport slave (
      input  res_valid, res_a, res_b, res_rd, res_n64, res_p8, res_n1, res_err,
      output res_ready
   );
endinterface

// File: rtl/conv_sequencer_phase_cnt.sv
// -----------------------------------------------------------------------------
// phase_cnt
//   Saturating up-counter that times one slope phase.
//   Ports: clk, rst (sync, active low), clr (load 1: the entry clock counts),
//          en (advance by one), cnt (W bits), sat (cnt is all ones).
//   clr wins over en; once saturated the count holds until the next clr.
// -----------------------------------------------------------------------------
module phase_cnt #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         en,
   output logic [W-1:0] cnt,
   output logic         sat
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = W'(1);
      end else if (en && !sat) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;
   assign sat = &cnt_q;

endmodule

// File: rtl/conv_sequencer.sv
// -----------------------------------------------------------------------------
// conv_sequencer
//   Runs one multi-slope conversion: zero -> runup -> rundown -> N64 -> P8 ->
//   N1, then hands the counts to the host.
//   Inputs : clk, rst (sync, active low), start, abort, runup_periods[15:0],
//            zeroLevel (async comparator), pwm_a/pwm_b[31:0].
//   Outputs: szero, sinput, sp512, sn64, sp8, sn1 (registered one-hot switch
//            decode of the next state), pwm_start, pwm_reload, busy, overrun
//            (sticky until reset), dbg_state (current FSM state).
//   res    : result handshake (master side of conv_sequencer_if).
// -----------------------------------------------------------------------------
module conv_sequencer
   import mslope_pkg::*;
#(
   parameter int CLK_DIV  = 250,
   parameter int ZERO_CYC = 5000,
   parameter int RD_W     = RD_W_DEF,
   parameter int FN_W     = FN_W_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        abort,
   input  logic [15:0] runup_periods,
   input  logic        zeroLevel,
   input  logic [31:0] pwm_a,
   input  logic [31:0] pwm_b,
   output logic        szero,
   output logic        sinput,
   output logic        pwm_start,
   output logic        pwm_reload,
   output logic        sp512,
   output logic        sn64,
   output logic        sp8,
   output logic        sn1,
   output logic        busy,
   output logic        overrun,
   output state_t      dbg_state,
   conv_sequencer_if.master res
);

   // One timer serves both the ZERO hold and the runup PWM period.
   localparam int TMR_MAX = (ZERO_CYC > CLK_DIV) ? ZERO_CYC : CLK_DIV;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);

   // ---------------- comparator synchroniser ----------------
   logic zl_meta_q;
   logic zl_q;
   logic zl;

   always_ff @(posedge clk) begin
      if (!rst) begin
         zl_meta_q <= 1'b0;
         zl_q      <= 1'b0;
      end else begin
         zl_meta_q <= zeroLevel;
         zl_q      <= zl_meta_q;
      end
   end

   assign zl = zl_q;

   // ---------------- FSM and phase bookkeeping ----------------
   state_t          state_q, state_d;
   logic [TMR_W-1:0] tmr_q, tmr_d;
   logic [15:0]     per_q, per_d;
   logic [15:0]     per_tgt_q, per_tgt_d;
   logic            err_q, err_d;
   logic [31:0]     a_lat_q, a_lat_d;
   logic [31:0]     b_lat_q, b_lat_d;
   logic [FN_W-1:0] n64_q, n64_d;
   logic [FN_W-1:0] p8_q, p8_d;

   logic            runup_wrap;
   logic            runup_last;

   logic [RD_W-1:0] rd_cnt;
   logic            rd_sat;
   logic            rd_clr;
   logic            rd_en;
   logic [FN_W-1:0] fn_cnt;
   logic            fn_sat;
   logic            fn_clr;
   logic            fn_en;

   always_comb begin
      state_d   = state_q;
      tmr_d     = tmr_q;
      per_d     = per_q;
      per_tgt_d = per_tgt_q;
      err_d     = err_q;
      a_lat_d   = a_lat_q;
      b_lat_d   = b_lat_q;
      n64_d     = n64_q;
      p8_d      = p8_q;

      runup_wrap = (state_q == ST_RUNUP) && (tmr_q == TMR_W'(CLK_DIV - 1));
      // The final wrap ends runup instead of reloading the PWM.
      runup_last = runup_wrap && (per_q == per_tgt_q - 16'd1);

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d   = ST_ZERO;
               tmr_d     = '0;
               per_tgt_d = (runup_periods == 16'd0) ? 16'd1 : runup_periods;
               err_d     = 1'b0;
            end
         end
         ST_ZERO: begin
            if (tmr_q == TMR_W'(ZERO_CYC - 1)) begin
               state_d = ST_RUNUP;
               tmr_d   = '0;
               per_d   = '0;
            end else begin
               tmr_d = tmr_q + TMR_W'(1);
            end
         end
         ST_RUNUP: begin
            if (runup_wrap) begin
               tmr_d = '0;
               if (runup_last) begin
                  state_d = ST_RUNDOWN;
                  a_lat_d = pwm_a;
                  b_lat_d = pwm_b;
               end else begin
                  per_d = per_q + 16'd1;
               end
            end else begin
               tmr_d = tmr_q + TMR_W'(1);
            end
         end
         // Each slope runs until the comparator flips; a saturated counter
         // ends the slope the same way and flags the result.
         ST_RUNDOWN: begin
            if (!zl || rd_sat) begin
               state_d = ST_N64;
               err_d   = err_q | rd_sat;
            end
         end
         ST_N64: begin
            if (zl || fn_sat) begin
               state_d = ST_P8;
               n64_d   = fn_cnt;
               err_d   = err_q | fn_sat;
            end
         end
         ST_P8: begin
            if (!zl || fn_sat) begin
               state_d = ST_N1;
               p8_d    = fn_cnt;
               err_d   = err_q | fn_sat;
            end
         end
         ST_N1: begin
            if (zl || fn_sat) begin
               state_d = ST_DONE;
               err_d   = err_q | fn_sat;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (abort) begin
         state_d = ST_IDLE;
      end
   end

   // Counters restart on entry and only advance while the phase continues,
   // so after the exit clock they still hold the finished phase's count.
   assign rd_clr = (state_d == ST_RUNDOWN) && (state_q != ST_RUNDOWN);
   assign rd_en  = (state_q == ST_RUNDOWN) && (state_d == ST_RUNDOWN);
   assign fn_clr = is_fine(state_d) && (state_d != state_q);
   assign fn_en  = is_fine(state_q) && (state_d == state_q);

   phase_cnt #(.W(RD_W)) u_rd_cnt (
      .clk (clk),
      .rst (rst),
      .clr (rd_clr),
      .en  (rd_en),
      .cnt (rd_cnt),
      .sat (rd_sat)
   );

   // N64, P8 and N1 never overlap, so they share one counter; N64 and P8
   // are parked in n64_q/p8_q when their phase ends.
   phase_cnt #(.W(FN_W)) u_fn_cnt (
      .clk (clk),
      .rst (rst),
      .clr (fn_clr),
      .en  (fn_en),
      .cnt (fn_cnt),
      .sat (fn_sat)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         tmr_q     <= '0;
         per_q     <= '0;
         per_tgt_q <= 16'd1;
         err_q     <= 1'b0;
         a_lat_q   <= '0;
         b_lat_q   <= '0;
         n64_q     <= '0;
         p8_q      <= '0;
      end else begin
         state_q   <= state_d;
         tmr_q     <= tmr_d;
         per_q     <= per_d;
         per_tgt_q <= per_tgt_d;
         err_q     <= err_d;
         a_lat_q   <= a_lat_d;
         b_lat_q   <= b_lat_d;
         n64_q     <= n64_d;
         p8_q      <= p8_d;
      end
   end

   // ---------------- registered control outputs ----------------
   sw_t  sw_q, sw_d;
   logic busy_q, busy_d;
   logic pwm_start_q, pwm_start_d;
   logic pwm_reload_q, pwm_reload_d;

   always_comb begin
      sw_d         = sw_decode(state_d);
      busy_d       = (state_d != ST_IDLE);
      pwm_start_d  = (state_q == ST_ZERO) && (state_d == ST_RUNUP);
      pwm_reload_d = runup_wrap && !runup_last && !abort;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         sw_q         <= '0;
         busy_q       <= 1'b0;
         pwm_start_q  <= 1'b0;
         pwm_reload_q <= 1'b0;
      end else begin
         sw_q         <= sw_d;
         busy_q       <= busy_d;
         pwm_start_q  <= pwm_start_d;
         pwm_reload_q <= pwm_reload_d;
      end
   end

   // ---------------- result register and handshake ----------------
   logic            res_valid_q, res_valid_d;
   logic [31:0]     res_a_q, res_a_d;
   logic [31:0]     res_b_q, res_b_d;
   logic [RD_W-1:0] res_rd_q, res_rd_d;
   logic [FN_W-1:0] res_n64_q, res_n64_d;
   logic [FN_W-1:0] res_p8_q, res_p8_d;
   logic [FN_W-1:0] res_n1_q, res_n1_d;
   logic            res_err_q, res_err_d;
   logic            overrun_q, overrun_d;
   logic            done_now;
   logic            done_load;

   always_comb begin
      res_valid_d = res_valid_q;
      res_a_d     = res_a_q;
      res_b_d     = res_b_q;
      res_rd_d    = res_rd_q;
      res_n64_d   = res_n64_q;
      res_p8_d    = res_p8_q;
      res_n1_d    = res_n1_q;
      res_err_d   = res_err_q;
      overrun_d   = overrun_q;

      done_now  = (state_q == ST_DONE) && !abort;
      // A host accept in the DONE clock frees the slot for the new result.
      done_load = done_now && (!res_valid_q || res.res_ready);

      if (res_valid_q && res.res_ready) begin
         res_valid_d = 1'b0;
      end

      if (done_load) begin
         res_valid_d = 1'b1;
         res_a_d     = a_lat_q;
         res_b_d     = b_lat_q;
         res_rd_d    = rd_cnt;
         res_n64_d   = n64_q;
         res_p8_d    = p8_q;
         res_n1_d    = fn_cnt;
         res_err_d   = err_q;
      end else if (done_now) begin
         overrun_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         res_valid_q <= 1'b0;
         res_a_q     <= '0;
         res_b_q     <= '0;
         res_rd_q    <= '0;
         res_n64_q   <= '0;
         res_p8_q    <= '0;
         res_n1_q    <= '0;
         res_err_q   <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         res_valid_q <= res_valid_d;
         res_a_q     <= res_a_d;
         res_b_q     <= res_b_d;
         res_rd_q    <= res_rd_d;
         res_n64_q   <= res_n64_d;
         res_p8_q    <= res_p8_d;
         res_n1_q    <= res_n1_d;
         res_err_q   <= res_err_d;
         overrun_q   <= overrun_d;
      end
   end

   // ---------------- output mapping ----------------
   assign szero      = sw_q.szero;
   assign sinput     = sw_q.sinput;
   assign sp512      = sw_q.sp512;
   assign sn64       = sw_q.sn64;
   assign sp8        = sw_q.sp8;
   assign sn1        = sw_q.sn1;
   assign busy       = busy_q;
   assign pwm_start  = pwm_start_q;
   assign pwm_reload = pwm_reload_q;
   assign overrun    = overrun_q;
   assign dbg_state  = state_q;

   assign res.res_valid = res_valid_q;
   assign res.res_a     = res_a_q;
   assign res.res_b     = res_b_q;
   assign res.res_rd    = res_rd_q;
   assign res.res_n64   = res_n64_q;
   assign res.res_p8    = res_p8_q;
   assign res.res_n1    = res_n1_q;
   assign res.res_err   = res_err_q;

endmodule
